// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared types for the I2C command sequencer: FSM encoding, queued command and response entries.
// Pure declarations; no timing or flow-control behaviour of its own.
// Entry widths are fixed by the packed structs (command 16 bits, response 17 bits).
package i2c_cmd_sequencer_pkg;

    localparam int CMD_W = 16;
    localparam int RSP_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_PUSH_RSP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Host-side command/response bundle; the host drives through master, the sequencer sits on slave.
// Wires only, no latency of its own.
// valid/ready on both directions; a beat moves when valid and ready are high together.
interface i2c_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [6:0] rsp_addr;
    logic       rsp_rw;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_rw, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_rw, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/i2c_cmd_sequencer_sync_fifo.sv
// i2c_sync_fifo: single-clock first-word-fall-through FIFO, DEPTH a power of two >= 2.
// Latency: a written word is visible at rd_dat the cycle after the write.
// Backpressure: wr_rdy is low whenever full, even if a pop happens in the same cycle.
module i2c_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_rdy && rd_vld;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands and runs them one at a time on i2c_master; watchdog via I2C_CMDQ_TIMEOUT_EN.
// Latency: >= 4 cycles plus master busy time per command; responses return in command order.
// Backpressure: cmd_ready drops when the command FIFO is full; no issue while the response FIFO is full.
module i2c_cmd_sequencer
    import i2c_cmd_sequencer_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int RSP_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    i2c_cmd_sequencer_if.slave      host,
    output logic [6:0]              m_addr,
    output logic [7:0]              m_data_in,
    output logic                    m_rw,
    output logic                    m_enable,
    input  logic [7:0]              m_read_data,
    input  logic                    m_ready,
    output logic                    busy
);

    state_t state, state_nxt;
    cmd_t   cmd_in, cmd_head, held;
    rsp_t   rsp_in, rsp_head;
    logic   cmd_head_vld, cmd_pop;
    logic   rsp_wr_rdy, rsp_push, rsp_head_vld;
    logic   cap_rdata;
    logic   wd_expired;
    logic   err_bit;
    logic [7:0] rdata_q;

    assign cmd_in = {host.cmd_addr, host.cmd_rw, host.cmd_wdata};

    i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (host.cmd_valid),
        .wr_rdy (host.cmd_ready),
        .wr_dat (cmd_in),
        .rd_vld (cmd_head_vld),
        .rd_rdy (cmd_pop),
        .rd_dat (cmd_head)
    );

    assign rsp_in = {held.addr, held.rw, rdata_q, err_bit};

    i2c_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (rsp_push),
        .wr_rdy (rsp_wr_rdy),
        .wr_dat (rsp_in),
        .rd_vld (rsp_head_vld),
        .rd_rdy (host.rsp_ready),
        .rd_dat (rsp_head)
    );

    // FIFO storage is not reset, so the head is masked until it holds a real entry.
    assign host.rsp_valid = rsp_head_vld;
    assign host.rsp_addr  = rsp_head_vld ? rsp_head.addr  : 7'h00;
    assign host.rsp_rw    = rsp_head_vld ? rsp_head.rw    : 1'b0;
    assign host.rsp_rdata = rsp_head_vld ? rsp_head.rdata : 8'h00;
    assign host.rsp_err   = rsp_head_vld ? rsp_head.err   : 1'b0;

    assign m_addr    = held.addr;
    assign m_data_in = held.wdata;
    assign m_rw      = held.rw;
    assign m_enable  = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        cap_rdata = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_head_vld && rsp_wr_rdy && m_ready) begin
                    cmd_pop   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:      state_nxt = ST_WAIT_START;
            ST_WAIT_START: begin
                if (!m_ready)        state_nxt = ST_WAIT_DONE;
                else if (wd_expired) state_nxt = ST_PUSH_RSP;
            end
            ST_WAIT_DONE: begin
                if (m_ready) begin
                    cap_rdata = 1'b1;
                    state_nxt = ST_PUSH_RSP;
                end else if (wd_expired) begin
                    state_nxt = ST_PUSH_RSP;
                end
            end
            ST_PUSH_RSP: begin
                rsp_push  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held    <= '0;
            rdata_q <= 8'h00;
        end else if (cmd_pop) begin
            held    <= cmd_head;
            rdata_q <= 8'h00;
        end else if (cap_rdata) begin
            rdata_q <= held.rw ? m_read_data : 8'h00;
        end
    end

`ifdef I2C_CMDQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            waiting;

    assign waiting    = (state == ST_WAIT_START) || (state == ST_WAIT_DONE);
    assign wd_expired = waiting && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign err_bit    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= waiting ? wd_cnt + 1'b1 : '0;
            if (cmd_pop)
                err_q <= 1'b0;
            else if (waiting && !cap_rdata && state_nxt == ST_PUSH_RSP)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign wd_expired = 1'b0;
    assign err_bit    = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: table of commands plus hand-built full/backpressure/reset sequences,
// with a behavioural i2c_master and queue-based scoreboards for issued commands and responses.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;
    import i2c_cmd_sequencer_pkg::*;

`ifdef I2C_CMDQ_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic [7:0] m_read_data;
    logic       m_ready;
    logic       busy;

    i2c_cmd_sequencer_if hif();

    i2c_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif.slave),
        .m_addr      (m_addr),
        .m_data_in   (m_data_in),
        .m_rw        (m_rw),
        .m_enable    (m_enable),
        .m_read_data (m_read_data),
        .m_ready     (m_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   n_issue  = 0;
    int   n_rsp    = 0;
    int   busy_cyc = 3;
    logic ext_busy = 1'b0;
    logic stuck    = 1'b0;
    cmd_t iss_q[$];
    rsp_t rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        return {1'b0, a} ^ 8'h76;
    endfunction

    // Behavioural i2c_master: drops ready after enable, holds busy_cyc cycles, returns model_rd(addr).
    initial begin : master_model
        cmd_t       exp_c;
        logic [6:0] cap_addr;
        m_ready     = 1'b1;
        m_read_data = 8'h00;
        forever begin
            @(negedge clk); #1;
            if (m_enable) begin
                chk("enable_while_busy", m_ready, 1);
                n_issue++;
                chk("issue_pending", iss_q.size() > 0, 1);
                if (iss_q.size() > 0) begin
                    exp_c = iss_q.pop_front();
                    chk("m_addr", m_addr, exp_c.addr);
                    chk("m_rw", m_rw, exp_c.rw);
                    if (!exp_c.rw) chk("m_data_in", m_data_in, exp_c.wdata);
                end
                cap_addr    = m_addr;
                m_read_data = 8'hA5;
                if (!stuck) begin
                    m_ready = 1'b0;
                    for (int i = 0; i < busy_cyc; i++) begin
                        @(negedge clk); #1;
                        chk("enable_pulse", m_enable, 0);
                        if (busy) chk("addr_stable", m_addr, cap_addr);
                    end
                    m_read_data = model_rd(cap_addr);
                    m_ready     = !ext_busy;
                end
            end else begin
                m_ready = !ext_busy;
            end
        end
    end

    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge clk); #1;
            if (hif.rsp_valid && hif.rsp_ready && !rst) begin
                n_rsp++;
                chk("rsp_expected", rsp_q.size() > 0, 1);
                if (rsp_q.size() > 0) begin
                    e = rsp_q.pop_front();
                    chk("rsp_addr", hif.rsp_addr, e.addr);
                    chk("rsp_rw", hif.rsp_rw, e.rw);
                    chk("rsp_rdata", hif.rsp_rdata, e.rdata);
                    chk("rsp_err", hif.rsp_err, e.err);
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge with cmd_valid low.
    task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        input logic [7:0] er, input logic ee);
        cmd_t c;
        rsp_t r;
        bit   ok = 1'b0;
        c = {a, rw, wd};
        r = {a, rw, er, ee};
        hif.cmd_valid = 1'b1;
        hif.cmd_addr  = a;
        hif.cmd_rw    = rw;
        hif.cmd_wdata = wd;
        for (int n = 0; n < 200 && !ok; n++) begin
            #1;
            if (hif.cmd_ready) begin
                ok = 1'b1;
                iss_q.push_back(c);
                rsp_q.push_back(r);
            end
            @(negedge clk);
        end
        hif.cmd_valid = 1'b0;
        chk("cmd_accept", ok, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((rsp_q.size() != 0 || busy || hif.rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 500, 1);
    endtask

    initial begin : global_limit
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        vec_t tbl[6];
        int   base;
        int   n;
        logic [6:0] a;

        tbl[0] = '{7'h2A, 1'b0, 8'hEB, 8'h00};
        tbl[1] = '{7'h2A, 1'b1, 8'h00, 8'h5C};
        tbl[2] = '{7'h11, 1'b0, 8'hA5, 8'h00};
        tbl[3] = '{7'h7F, 1'b1, 8'hFF, 8'h09};
        tbl[4] = '{7'h00, 1'b1, 8'h00, 8'h76};
        tbl[5] = '{7'h55, 1'b0, 8'h3C, 8'h00};

        hif.cmd_valid = 1'b0;
        hif.cmd_addr  = 7'h00;
        hif.cmd_rw    = 1'b0;
        hif.cmd_wdata = 8'h00;
        hif.rsp_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", hif.cmd_ready, 1);
        chk("rst_rsp_valid", hif.rsp_valid, 0);
        chk("rst_m_enable", m_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_data_in", m_data_in, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_rsp_addr", hif.rsp_addr, 0);
        chk("rst_rsp_rdata", hif.rsp_rdata, 0);
        chk("rst_rsp_err", hif.rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single commands from the table, one at a time.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].addr, tbl[i].rw, tbl[i].wdata, tbl[i].exp_rdata, 1'b0);
            drain("vec_drain");
        end
        chk("vec_rsp_count", n_rsp, 6);

        // Master held busy: command FIFO fills and the fifth push is refused until the first issue.
        ext_busy = 1'b1;
        @(negedge clk);
        base = n_issue;
        for (int i = 0; i < 4; i++) begin
            a = 7'h30 + 7'(i);
            send(a, i[0], 8'h10 + 8'(i), i[0] ? model_rd(a) : 8'h00, 1'b0);
        end
        hif.cmd_valid = 1'b1;
        hif.cmd_addr  = 7'h34;
        hif.cmd_rw    = 1'b1;
        hif.cmd_wdata = 8'h00;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_cmd_ready", hif.cmd_ready, 0);
            chk("full_no_issue", n_issue - base, 0);
            @(negedge clk);
        end
        ext_busy = 1'b0;
        send(7'h34, 1'b1, 8'h00, model_rd(7'h34), 1'b0);
        chk("full_accept_after_issue", n_issue - base, 1);
        drain("full_drain");
        chk("full_issue_total", n_issue - base, 5);

        // Response backpressure: only RSP_DEPTH commands may issue.
        hif.rsp_ready = 1'b0;
        base = n_issue;
        for (int i = 0; i < 6; i++) begin
            a = 7'h40 + 7'(i);
            send(a, ~i[0], 8'hC0 + 8'(i), ~i[0] ? model_rd(a) : 8'h00, 1'b0);
        end
        repeat (60) @(negedge clk);
        chk("bp_issue_count", n_issue - base, 4);
        chk("bp_idle", busy, 0);
        chk("bp_rsp_valid", hif.rsp_valid, 1);
        hif.rsp_ready = 1'b1;
        drain("bp_drain");
        chk("bp_resume_count", n_issue - base, 6);

        // Reset during WAIT_DONE with a response already queued.
        hif.rsp_ready = 1'b0;
        busy_cyc = 8;
        base = n_issue;
        send(7'h21, 1'b0, 8'h99, 8'h00, 1'b0);
        send(7'h22, 1'b1, 8'h00, model_rd(7'h22), 1'b0);
        n = 0;
        while (n_issue < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_issue_seen", n_issue - base, 2);
        repeat (2) @(negedge clk);
        chk("rst_mid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_m_enable", m_enable, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rsp_valid", hif.rsp_valid, 0);
        chk("rst_mid_cmd_ready", hif.cmd_ready, 1);
        rsp_q.delete();
        iss_q.delete();
        @(negedge clk);
        rst = 1'b0;
        hif.rsp_ready = 1'b1;
        busy_cyc = 3;
        send(7'h44, 1'b1, 8'h00, model_rd(7'h44), 1'b0);
        drain("post_rst_drain");

`ifdef I2C_CMDQ_TIMEOUT_EN
        // Master never goes busy: watchdog closes the command with err=1.
        stuck = 1'b1;
        hif.rsp_ready = 1'b0;
        send(7'h2A, 1'b1, 8'h00, 8'h00, 1'b1);
        n = 0;
        while (!hif.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency_lo", n >= 17, 1);
        chk("to_latency_hi", n <= 21, 1);
        hif.rsp_ready = 1'b1;
        drain("to_drain");
        stuck = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
